// File: rtl/door_lock_pkg.sv
// Shared types and width helpers for the door lock access-control slice.
package door_lock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  function automatic int fail_w(input int max_fail);
    return $clog2(max_fail + 1);
  endfunction

  // A single counter serves both timed states, so it is sized for the longer one.
  function automatic int timer_w(input int open_cycles, input int lock_cycles);
    int longest;
    longest = (open_cycles > lock_cycles) ? open_cycles : lock_cycles;
    return ($clog2(longest) < 1) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/door_lock_ctrl_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT states; clr beats load.
module lock_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/door_lock_ctrl.sv
// Access-control FSM downstream of the password comparator: door open, failure
// counting with lockout/alarm, and a keypad entry-clear pulse.
module door_lock_ctrl
  import door_lock_pkg::*;
#(
  parameter int OPEN_CYCLES = 50_000_000,
  parameter int LOCK_CYCLES = 500_000_000,
  parameter int MAX_FAIL    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sharp,
  input  logic                       pw_match,
  input  logic                       admin_clr,
  output logic                       door_open,
  output logic                       alarm,
  output logic [fail_w(MAX_FAIL)-1:0] fail_cnt,
  output logic                       clr_entry
);

  localparam int FW = fail_w(MAX_FAIL);
  localparam int TW = timer_w(OPEN_CYCLES, LOCK_CYCLES);

  localparam logic [1:0]    ST_IDLE    = IDLE;
  localparam logic [1:0]    ST_OPEN    = OPEN;
  localparam logic [1:0]    ST_LOCKOUT = LOCKOUT;
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);

  logic          sharp_q;
  logic          sub;
  logic [1:0]    state, state_nxt;
  logic [FW-1:0] fail_nxt;
  logic          clr_nxt;
  logic          tmr_load, tmr_clr, tmr_zero;
  logic [TW-1:0] tmr_val;

  assign sub = sharp & ~sharp_q;

  lock_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .clr      (tmr_clr),
    .zero     (tmr_zero)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    fail_nxt  = fail_cnt;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_clr   = 1'b0;
    clr_nxt   = sub && (state != ST_LOCKOUT);

    if (admin_clr) begin
      state_nxt = ST_IDLE;
      fail_nxt  = '0;
      tmr_clr   = 1'b1;
      clr_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sub && pw_match) begin
            state_nxt = ST_OPEN;
            fail_nxt  = '0;
            tmr_load  = 1'b1;
            tmr_val   = OPEN_LOAD;
          end else if (sub) begin
            fail_nxt = (fail_cnt == FAIL_MAX) ? FAIL_MAX : fail_cnt + FW'(1);
            if (fail_nxt == FAIL_MAX) begin
              state_nxt = ST_LOCKOUT;
              tmr_load  = 1'b1;
              tmr_val   = LOCK_LOAD;
            end
          end
        end
        // Expiry and a manual relock both land in IDLE; clr_entry still follows sub.
        ST_OPEN: begin
          if (tmr_zero || sub) begin
            state_nxt = ST_IDLE;
            tmr_clr   = 1'b1;
          end
        end
        ST_LOCKOUT: begin
          if (tmr_zero) begin
            state_nxt = ST_IDLE;
            fail_nxt  = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          fail_nxt  = '0;
          tmr_clr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sharp_q   <= 1'b0;
      state     <= ST_IDLE;
      fail_cnt  <= '0;
      clr_entry <= 1'b0;
    end else begin
      sharp_q   <= sharp;
      state     <= state_nxt;
      fail_cnt  <= fail_nxt;
      clr_entry <= clr_nxt;
    end
  end

  assign door_open = (state == ST_OPEN);
  assign alarm     = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Directed plus randomized bench for door_lock_ctrl against a remaining-cycles
// reference model (OPEN_CYCLES=4, LOCK_CYCLES=8, MAX_FAIL=3).
module tb_door_lock_ctrl;

  localparam int OPEN_C = 4;
  localparam int LOCK_C = 8;
  localparam int MAXF   = 3;

  logic       clk;
  logic       rst;
  logic       sharp;
  logic       pw_match;
  logic       admin_clr;
  logic       door_open;
  logic       alarm;
  logic [1:0] fail_cnt;
  logic       clr_entry;

  int n_vec;
  int n_err;

  // Reference model: remaining open/lock cycles, failure count, last sharp level.
  int m_open_left;
  int m_lock_left;
  int m_fails;
  int m_prev_sharp;
  int m_clr;

  door_lock_ctrl #(
    .OPEN_CYCLES (OPEN_C),
    .LOCK_CYCLES (LOCK_C),
    .MAX_FAIL    (MAXF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sharp     (sharp),
    .pw_match  (pw_match),
    .admin_clr (admin_clr),
    .door_open (door_open),
    .alarm     (alarm),
    .fail_cnt  (fail_cnt),
    .clr_entry (clr_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int sub;
    sub = (sharp && m_prev_sharp == 0) ? 1 : 0;
    m_prev_sharp = rst ? 0 : int'(sharp);
    m_clr = 0;
    if (rst || admin_clr) begin
      m_open_left = 0;
      m_lock_left = 0;
      m_fails     = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open_left > 0) begin
      m_clr = sub;
      m_open_left = sub ? 0 : m_open_left - 1;
    end else if (sub == 1) begin
      m_clr = 1;
      if (pw_match) begin
        m_open_left = OPEN_C;
        m_fails     = 0;
      end else begin
        m_fails = (m_fails + 1 > MAXF) ? MAXF : m_fails + 1;
        if (m_fails == MAXF) m_lock_left = LOCK_C;
      end
    end
  endtask

  task automatic step(input logic s, input logic p, input logic a = 1'b0, input logic r = 1'b0);
    sharp     = s;
    pw_match  = p;
    admin_clr = a;
    rst       = r;
    @(posedge clk);
    model_edge();
    #1;
    check("door_open", 32'(door_open), 32'(m_open_left > 0));
    check("alarm",     32'(alarm),     32'(m_lock_left > 0));
    check("fail_cnt",  32'(fail_cnt),  32'(m_fails));
    check("clr_entry", 32'(clr_entry), 32'(m_clr));
  endtask

  initial begin
    int cnt;
    logic s;
    n_vec = 0;
    n_err = 0;
    m_open_left = 0;
    m_lock_left = 0;
    m_fails = 0;
    m_prev_sharp = 0;
    m_clr = 0;
    sharp = 1'b0;
    pw_match = 1'b0;
    admin_clr = 1'b0;
    rst = 1'b1;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0);

    // Successful submit: door open for exactly OPEN_C cycles
    step(1, 1);
    cnt = int'(door_open);
    for (int i = 0; i < 6; i++) begin
      step(0, 0);
      cnt += int'(door_open);
    end
    check("open_len", 32'(cnt), 32'(OPEN_C));

    // Three failures into lockout, a submit ignored during lockout
    for (int k = 1; k <= 3; k++) begin
      step(1, 0);
      check("fail_step", 32'(fail_cnt), 32'(k));
      step(0, 0);
    end
    step(1, 1);
    check("lock_sub_ignored", 32'(clr_entry), 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      cnt += int'(alarm);
    end
    check("after_lock_fail", 32'(fail_cnt), 32'd0);

    // Held key counts once
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      cnt += int'(clr_entry);
    end
    check("held_clr_pulses", 32'(cnt), 32'd1);
    check("held_fail", 32'(fail_cnt), 32'd1);
    step(0, 0, 1);

    // Manual relock in second open cycle
    step(1, 1);
    step(0, 0);
    step(1, 0);
    check("relock_door", 32'(door_open), 32'd0);
    step(0, 0);

    // Submit coinciding with the last open cycle
    step(1, 1);
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("last_cycle_door", 32'(door_open), 32'd0);
    check("last_cycle_clr", 32'(clr_entry), 32'd1);
    step(0, 0);

    // Two failures, admin clear, success then failure
    step(1, 0); step(0, 0);
    step(1, 0); step(0, 0);
    step(0, 0, 1);
    check("admin_fail", 32'(fail_cnt), 32'd0);
    step(1, 1);
    for (int i = 0; i < 6; i++) step(0, 0);
    step(1, 0);
    check("succ_then_fail", 32'(fail_cnt), 32'd1);
    step(0, 0);
    check("no_lockout", 32'(alarm), 32'd0);

    // Reset mid-lockout, then a normal open
    step(1, 0); step(0, 0);
    step(1, 0); step(0, 0);
    step(0, 0);
    step(0, 0, 0, 1);
    check("rst_alarm", 32'(alarm), 32'd0);
    check("rst_fail", 32'(fail_cnt), 32'd0);
    step(1, 1);
    check("post_rst_open", 32'(door_open), 32'd1);
    step(0, 0);

    // Randomized traffic against the model
    s = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      step(s, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 149) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/door_lock_ctrl.md
# door_lock_ctrl

Access-control state machine sitting directly downstream of the password comparator in the digital door lock. It turns the comparator's match result, qualified by the `#` (sharp) submit key, into door-open, failed-attempt counting, lockout/alarm and an entry-clear pulse. The entry-clear pulse goes back to the keypad input register.

## Interface
Parameters:
- `OPEN_CYCLES`, default 50_000_000: clock cycles `door_open` stays high after a successful attempt (≥1)
- `LOCK_CYCLES`, default 500_000_000: clock cycles of lockout after too many failures (≥1)
- `MAX_FAIL`, default 3: consecutive failed attempts that trigger lockout (≥1)

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `sharp`  in  1  `#` key level, already synchronised to `clk`; the block edge-detects it internally
- `pw_match`  in  1  comparator result (1 = entered code equals stored code); sampled only in the cycle a sharp edge is detected
- `admin_clr`  in  1  synchronous level; forces return to IDLE and clears the failure count
- `door_open`  out  1  door unlock drive
- `alarm`  out  1  high throughout LOCKOUT
- `fail_cnt`  out  $clog2(MAX_FAIL+1)  current consecutive-failure count
- `clr_entry`  out  1  one-cycle pulse requesting the keypad input register to clear

## Operation
- Submit event: `sub = sharp & ~sharp_q`. `sharp_q` is a register of `sharp`. A held key yields exactly one event.
- States:
  - IDLE: waiting for a submit.
  - OPEN: door unlocked, open timer running.
  - LOCKOUT: alarm active, lock timer running.
- IDLE:
  - `sub & pw_match` -> OPEN. Load the timer with OPEN_CYCLES-1 and clear `fail_cnt`.
  - `sub & ~pw_match` -> increment `fail_cnt`. If the new value equals MAX_FAIL, go to LOCKOUT and load the timer with LOCK_CYCLES-1. Otherwise stay in IDLE.
- OPEN:
  - Timer decrements each cycle.
  - Timer == 0 -> IDLE.
  - `sub` while in OPEN -> IDLE immediately (manual relock). `pw_match` is ignored.
- LOCKOUT:
  - `sub` is ignored; `fail_cnt` holds at MAX_FAIL.
  - Timer == 0 -> IDLE with `fail_cnt` cleared.
- `clr_entry`: pulses for one cycle, in the cycle after every `sub` accepted in IDLE or OPEN. A `sub` ignored in LOCKOUT produces no pulse.
- Priority, highest first: `rst` > `admin_clr` > timer expiry > `sub`.
  - `admin_clr` -> IDLE, `fail_cnt` = 0, timer = 0, no `clr_entry`.
- `fail_cnt` saturates at MAX_FAIL and never wraps.
- Timer width is $clog2(max(OPEN_CYCLES, LOCK_CYCLES)), minimum 1.

## Timing
- Reset values: state IDLE, `sharp_q` = 0, timer = 0, and all outputs low (`door_open`, `alarm`, `fail_cnt` = 0, `clr_entry`).
- All outputs are registered, decoded from the state register or driven by flops; there are no combinational input-to-output paths.
- Latency: `sharp` first sampled high at edge N (with `pw_match` valid in that same cycle) -> `door_open`/`alarm`/`fail_cnt`/`clr_entry` update after edge N, visible in cycle N+1.
- `door_open` is high for exactly OPEN_CYCLES cycles unless cut short by `sub`, `admin_clr` or `rst`.
- `alarm` is high for exactly LOCK_CYCLES cycles.
- Reset mid-OPEN or mid-LOCKOUT: outputs drop in the cycle after the `rst` edge. `sharp_q` reset to 0 means a key still held across reset generates one `sub` on the first cycle after `rst` deasserts.
- Simultaneous `sub` and timer expiry in OPEN: expiry wins -> IDLE. The `sub` is consumed with no further action, but still produces `clr_entry`.

## Structure
- Package `door_lock_pkg`: state enum (IDLE, OPEN, LOCKOUT; 2-bit encoding) and the width function for `fail_cnt`.
- Sub-module `lock_timer`: loadable down-counter with inputs `load`, `load_val` and `clr`, and output `zero`. It is shared by OPEN and LOCKOUT because the two never overlap.
- The top level holds the FSM, edge detect, failure counter and output registers.

## Test plan
Use OPEN_CYCLES=4, LOCK_CYCLES=8, MAX_FAIL=3.
- Reset, then raise `sharp` with `pw_match`=1 -> `door_open` high in cycles N+1..N+4, `clr_entry` high in N+1 only, `fail_cnt`=0, then IDLE.
- Three submits with `pw_match`=0 (sharp released between them) -> `fail_cnt` 1, 2, 3. `alarm` goes high for 8 cycles after the third submit. A submit during the lockout causes no change and no `clr_entry`. After the lockout `fail_cnt`=0.
- `sharp` held high for 20 cycles with `pw_match`=0 -> exactly one failure counted and one `clr_entry` pulse.
- In OPEN at cycle 2, a new `sub` -> `door_open` low the next cycle. Separately, a `sub` coinciding with the last open cycle -> IDLE, `door_open` low, `clr_entry` pulses.
- Two failures, then `admin_clr` for 1 cycle -> `fail_cnt`=0. Then a success followed by a failure gives `fail_cnt`=1, with no lockout.
- `rst` asserted mid-LOCKOUT (cycle 3) -> `alarm`=0 and `fail_cnt`=0 the next cycle. A submit with `pw_match`=1 after reset opens the door normally.
